// File: rtl/thermo_pkg.sv
// rtl/thermo_pkg.sv - shared types and constants for the thermometer-code receiver
package thermo_pkg;

  localparam int FRAME_BITS = 8;
  localparam int IDX_W      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam logic [FRAME_BITS-1:0] THERMO_MIN = 8'h01;
  localparam logic [FRAME_BITS-1:0] THERMO_MAX = 8'hFF;

  // Legal code for address n: the low n+1 bits set.
  function automatic logic [FRAME_BITS-1:0] thermo_code(input int n);
    return FRAME_BITS'((1 << (n + 1)) - 1);
  endfunction

endpackage

// File: rtl/thermo_to_index.sv
// rtl/thermo_to_index.sv - combinational thermometer word to address decoder
module thermo_to_index
  import thermo_pkg::*;
(
  input  logic [FRAME_BITS-1:0] word,
  output logic [IDX_W-1:0]      addr,
  output logic                  error
);

  always_comb begin
    addr  = '0;
    error = 1'b1;
    for (int n = 0; n < FRAME_BITS; n++) begin
      if (word == thermo_code(n)) begin
        addr  = IDX_W'(n);
        error = 1'b0;
      end
    end
  end

endmodule

// File: rtl/thermo_rx.sv
// rtl/thermo_rx.sv - serial thermometer-code frame receiver with saturating error count
module thermo_rx
  import thermo_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  enable,
  input  logic                  serial_in,
  output logic [FRAME_BITS-1:0] word,
  output logic [IDX_W-1:0]      addr_out,
  output logic                  valid,
  output logic                  error,
  output logic [ERR_CNT_W-1:0]  err_count
);

  rx_state_t               state;
  logic [IDX_W-1:0]        bit_cnt;
  logic [FRAME_BITS-2:0]   shift;
  logic [FRAME_BITS-1:0]   frame;
  logic [IDX_W-1:0]        dec_addr;
  logic                    dec_err;

  // Bit 7 is never stored: the frame is decoded straight from serial_in on its last edge.
  assign frame = {serial_in, shift};

  thermo_to_index u_dec (
    .word  (frame),
    .addr  (dec_addr),
    .error (dec_err)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      word      <= '0;
      addr_out  <= '0;
      valid     <= 1'b0;
      error     <= 1'b0;
      err_count <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          shift   <= '0;
          if (enable) begin
            state   <= RECV;
            shift   <= {{(FRAME_BITS-2){1'b0}}, serial_in};
            bit_cnt <= IDX_W'(1);
          end
        end
        RECV: begin
          if (!enable) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
          end else begin
            bit_cnt <= bit_cnt + IDX_W'(1);
            if (bit_cnt == IDX_W'(FRAME_BITS - 1)) begin
              word     <= frame;
              addr_out <= dec_addr;
              error    <= dec_err;
              valid    <= 1'b1;
              if (dec_err && (err_count != {ERR_CNT_W{1'b1}}))
                err_count <= err_count + ERR_CNT_W'(1);
            end else begin
              shift[bit_cnt] <= serial_in;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thermo_rx.sv
// tb/tb_thermo_rx.sv - scoreboard bench for thermo_rx with 8-bit and 2-bit error counters
module tb_thermo_rx;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       enable;
  logic       serial_in;
  logic [7:0] word, word_s;
  logic [2:0] addr_out, addr_s;
  logic       valid, valid_s;
  logic       error, error_s;
  logic [7:0] err_count;
  logic [1:0] err_count_s;

  thermo_rx #(.ERR_CNT_W(8)) dut (
    .clock(clock), .clear_n(clear_n), .enable(enable), .serial_in(serial_in),
    .word(word), .addr_out(addr_out), .valid(valid), .error(error), .err_count(err_count)
  );

  thermo_rx #(.ERR_CNT_W(2)) dut_s (
    .clock(clock), .clear_n(clear_n), .enable(enable), .serial_in(serial_in),
    .word(word_s), .addr_out(addr_s), .valid(valid_s), .error(error_s), .err_count(err_count_s)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] w;
    logic [2:0] a;
    logic       e;
    logic [7:0] c;
    logic [1:0] cs;
    bit         gap;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   last_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input logic [7:0] w, input logic [2:0] a, input logic e,
                              input logic [7:0] c, input logic [1:0] cs, input bit g);
    exp_t x;
    x.w = w; x.a = a; x.e = e; x.c = c; x.cs = cs; x.gap = g;
    sbq.push_back(x);
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      @(negedge clock);
      enable    = 1'b1;
      serial_in = d[k];
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      enable = 1'b0;
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        cur = sbq.pop_front();
        chk("word", 32'(word), 32'(cur.w));
        chk("addr_out", 32'(addr_out), 32'(cur.a));
        chk("error", 32'(error), 32'(cur.e));
        chk("err_count", 32'(err_count), 32'(cur.c));
        chk("valid_small", 32'(valid_s), 32'd1);
        chk("err_count_small", 32'(err_count_s), 32'(cur.cs));
        if (cur.gap) chk("valid_gap", 32'(cyc - last_valid), 32'd8);
      end
      last_valid = cyc;
    end
  end

  logic [7:0] legal [8];
  logic [7:0] bad5  [5];

  initial begin
    legal = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    bad5  = '{8'h02, 8'h04, 8'hFE, 8'h55, 8'h81};
    clear_n = 1'b0; enable = 1'b0; serial_in = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_word", 32'(word), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    clear_n = 1'b1;

    // Legal codes back-to-back, then illegal frames continuing the stream
    for (int i = 0; i < 8; i++) begin
      expect_frame(legal[i], 3'(i), 1'b0, 8'd0, 2'd0, i != 0);
      send_bits(legal[i], 8);
    end
    expect_frame(8'h05, 3'd0, 1'b1, 8'd1, 2'd1, 1'b1); send_bits(8'h05, 8);
    expect_frame(8'h00, 3'd0, 1'b1, 8'd2, 2'd2, 1'b1); send_bits(8'h00, 8);
    expect_frame(8'h80, 3'd0, 1'b1, 8'd3, 2'd3, 1'b1); send_bits(8'h80, 8);
    idle(2);

    // Abort after bit 4, then a clean 0x0F frame
    send_bits(8'h3F, 5);
    idle(1);
    expect_frame(8'h0F, 3'd3, 1'b0, 8'd3, 2'd3, 1'b0);
    send_bits(8'h0F, 8);
    // Enable drops on the edge that would take bit 7
    send_bits(8'hFF, 7);
    idle(1);
    expect_frame(8'h07, 3'd2, 1'b0, 8'd3, 2'd3, 1'b0);
    send_bits(8'h07, 8);
    idle(2);

    // Asynchronous reset between edges, mid-frame
    send_bits(8'h7F, 3);
    @(posedge clock);
    #2 clear_n = 1'b0;
    #1;
    chk("arst_word", 32'(word), 32'd0);
    chk("arst_addr", 32'(addr_out), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_error", 32'(error), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_err_count_small", 32'(err_count_s), 32'd0);
    @(negedge clock);
    enable  = 1'b0;
    clear_n = 1'b1;
    expect_frame(8'h7F, 3'd6, 1'b0, 8'd0, 2'd0, 1'b0);
    send_bits(8'h7F, 8);
    idle(2);

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) begin
      expect_frame(bad5[i], 3'd0, 1'b1, 8'(i + 1), (i < 3) ? 2'(i + 1) : 2'd3, 1'b0);
      send_bits(bad5[i], 8);
    end
    idle(1);

    // Long disable with toggling data: no frames, word holds
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      enable    = 1'b0;
      serial_in = k[0];
    end
    chk("hold_word", 32'(word), 32'h81);
    chk("hold_word_small", 32'(word_s), 32'h81);
    chk("hold_valid", 32'(valid), 32'd0);

    repeat (4) @(negedge clock);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
